// File: rtl/seq_scan_ctrl_pkg.sv
// Shared encodings for the serial "00110" scan controller and its pattern recogniser.
package seq_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccept,
    StShift,
    StDone
  } scan_state_e;

  // Each state names the longest pattern prefix seen so far.
  typedef enum logic [2:0] {
    DetInit,
    DetSeen0,
    DetSeen00,
    DetSeen001,
    DetSeen0011
  } det_state_e;

  localparam logic [4:0] Pattern = 5'b00110;

  // Pattern bit in arrival order: pos 0 is the first serial bit.
  function automatic logic pat_bit(input logic [2:0] pos);
    return Pattern[3'd4 - pos];
  endfunction

endpackage

// File: rtl/seq_det_00110_core.sv
// Overlapping Mealy recogniser for the serial pattern 0,0,1,1,0; hit is combinational.
module seq_det_00110_core
  import seq_scan_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic hit
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DetInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (clr) begin
      state_d = DetInit;
    end else if (bit_en) begin
      unique case (state_q)
        DetInit:     state_d = (bit_in == pat_bit(3'd0)) ? DetSeen0 : DetInit;
        DetSeen0:    state_d = (bit_in == pat_bit(3'd1)) ? DetSeen00 : DetInit;
        DetSeen00:   state_d = (bit_in == pat_bit(3'd2)) ? DetSeen001 : DetSeen00;
        // "0010" still ends in a usable leading 0.
        DetSeen001:  state_d = (bit_in == pat_bit(3'd3)) ? DetSeen0011 : DetSeen0;
        DetSeen0011: begin
          if (bit_in == pat_bit(3'd4)) begin
            hit     = 1'b1;
            state_d = DetSeen0;
          end else begin
            state_d = DetInit;
          end
        end
        default:     state_d = DetInit;
      endcase
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan-session controller: accepts bytes, serialises them MSB first into the "00110"
// recogniser and counts matches (saturating) until the byte flagged last.
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              done
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  scan_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pulse_q;
  logic              det_clr, det_bit_en, det_bit_in, det_hit;

  assign det_bit_en = (state_q == StShift);
  assign det_bit_in = data_q[DATA_W-1];
  assign det_clr    = (state_q == StIdle) && start;

  seq_det_00110_core u_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (det_clr),
    .bit_en (det_bit_en),
    .bit_in (det_bit_in),
    .hit    (det_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      pulse_q <= det_hit;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    last_d   = last_q;
    idx_d    = idx_q;
    count_d  = count_q;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccept;
          count_d = '0;
        end
      end
      StAccept: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          idx_d   = IdxW'(DATA_W - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        data_d = data_q << 1;
        idx_d  = idx_q - 1'b1;
        if (det_hit && (count_q != '1)) begin
          count_d = count_q + 1'b1;
        end
        if (idx_q == '0) begin
          state_d = last_q ? StDone : StAccept;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign match_pulse = pulse_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: expected session results are queued when a session is
// driven and popped when the DUT signals done.
module tb_seq_scan_ctrl;

  localparam int CNT_W  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready, busy, match_pulse, done;
  logic [CNT_W-1:0]  match_count;

  seq_scan_ctrl #(
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int pulse_cnt = 0;
  int done_cnt  = 0;
  int exp_cnt_q[$];
  int exp_pulse_q[$];
  logic [7:0] sess_q[$];

  always @(negedge clk) begin
    if (match_pulse) pulse_cnt <= pulse_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_match_pulse"}, 32'(match_pulse), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_match_count"}, 32'(match_count), 0);
  endtask

  // Presents a byte and returns at the negedge after the capturing edge.
  task automatic send_byte(input logic [7:0] b, input logic last, input bit hold,
                           input string tag);
    bit ok;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_ready_seen"}, 32'(ok), 1);
    @(negedge clk);
    if (hold) begin
      in_data = 8'hFF;
      in_last = ~last;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic run_session(input int exp_cnt, input int exp_pulses, input bit hold,
                             input string tag);
    int p0;
    int k;
    int exp_c;
    int exp_p;
    logic [CNT_W-1:0] cnt_at_done;
    exp_cnt_q.push_back(exp_cnt);
    exp_pulse_q.push_back(exp_pulses);
    p0 = pulse_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    for (int i = 0; i < sess_q.size(); i++) begin
      send_byte(sess_q[i], (i == sess_q.size() - 1), hold, tag);
      if (i != sess_q.size() - 1) begin
        k = 0;
        while (!in_ready && k < 40) begin
          @(negedge clk);
          k++;
        end
        if (i == 0) check({tag, "_byte_gap"}, k, DATA_W);
      end
    end
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_latency"}, k, DATA_W);
    cnt_at_done = match_count;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_count_hold"}, 32'(match_count), 32'(cnt_at_done));
    exp_c = exp_cnt_q.pop_front();
    exp_p = exp_pulse_q.pop_front();
    check({tag, "_match_count"}, 32'(cnt_at_done), exp_c);
    check({tag, "_pulses"}, pulse_cnt - p0, exp_p);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    sess_q = '{8'h32};
    run_session(1, 1, 1'b0, "s32");
    sess_q = '{8'h03, 8'h00};
    run_session(1, 1, 1'b0, "s03_00");
    sess_q = '{8'h33, 8'h00};
    run_session(2, 2, 1'b0, "s33_00");
    sess_q = '{8'hFF};
    run_session(0, 0, 1'b0, "sFF");
    sess_q = '{8'h33, 8'h00};
    run_session(2, 2, 1'b1, "hold");

    // Abort a session mid-shift after its first match has been counted.
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h33, 1'b0, 1'b0, "abort");
    repeat (6) @(negedge clk);
    check("abort_pre_count", 32'(match_count), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    sess_q = '{8'h32};
    run_session(1, 1, 1'b0, "post_reset");

    sess_q.delete();
    for (int i = 0; i < 260; i++) sess_q.push_back(8'h32);
    run_session(255, 260, 1'b0, "saturate");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
